// File: rtl/param_stack.sv
// rtl/param_stack.sv - parametrised LIFO stack with status flags and error pulses
//
// Purpose: call/operand stack. Supports push, pop, peek (top), a combined
//   push+pop that replaces the top entry, and a synchronous clear.
//   All results appear one clock after the command is sampled.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous clear (empties the stack)
//   push       write d_in as the new top
//   pop        read the top to d_out and remove it
//   top        read the top to d_out without removing it
//   d_in       data to push
//   d_out      registered read data (held until the next read)
//   d_valid    one-cycle strobe: d_out was updated
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries, 0..DEPTH
//   overflow   one-cycle pulse: push rejected because the stack is full
//   underflow  one-cycle pulse: pop/top rejected because the stack is empty

module param_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic             top,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    next_idx;
  logic [WIDTH-1:0] top_data;
  logic             we;
  logic [AW-1:0]    waddr;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign top_idx  = AW'(count - ONE_C);
  assign next_idx = AW'(count);
  assign top_data = mem[top_idx];

  // Memory write decode follows the same priority as the control register
  // update so that exactly one action happens per cycle.
  always_comb begin
    we    = 1'b0;
    waddr = next_idx;
    if (!clr) begin
      if (push && pop) begin
        if (!empty) begin
          we    = 1'b1;
          waddr = top_idx;
        end
      end else if (!pop && push && !full) begin
        we    = 1'b1;
        waddr = next_idx;
      end
    end
  end

  // Storage is not reset; writes are suppressed while reset is held so an
  // aborted operation leaves no trace. The read of top_data above sees the
  // old contents in a same-address cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem[waddr] <= d_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      d_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (push && pop) begin
        // Replace-top; on an empty stack the input bypasses straight to d_out.
        d_valid <= 1'b1;
        d_out   <= empty ? d_in : top_data;
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          d_out   <= top_data;
          d_valid <= 1'b1;
          count   <= count - ONE_C;
        end
      end else if (push) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + ONE_C;
        end
      end else if (top) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          d_out   <= top_data;
          d_valid <= 1'b1;
        end
      end
    end
  end

endmodule
